// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, error codes, keyboard command bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    SHIFT,
    ACKWAIT
  } ps2_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_NACK    = 2'b01,
    ERR_TIMEOUT = 2'b10
  } ps2_err_e;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] RSP_ACK     = 8'hFA;

  // PS/2 frames carry odd parity over the 8 data bits.
  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// 2-FF synchroniser with registered falling-edge detect for a PS/2 pad.
// PS2_TX_CLK_FILTER_EN adds a FILTER_LEN-sample debounce ahead of the edge detector.
module ps2_sync_edge #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic pad_i,
  output logic level_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic       fall_q;
  logic       lvl;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], pad_i};
  end

`ifdef PS2_TX_CLK_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Level flips only once the new value has been seen FILTER_LEN times in a row.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) filt_d = sync_q[1];
      else                              cnt_d  = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync_q[1];
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      prev_q <= lvl;
      fall_q <= prev_q & ~lvl;
    end
  end

  assign level_o = lvl;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, clocked-out frame, ACK check.
// Define PS2_TX_CLK_FILTER_EN to debounce ps2_clk before edge detection.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  ps2_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       edge_q, edge_d;
  logic [7:0]       data_q, data_d;
  logic             par_q, par_d;
  logic             dout_q, dout_d;
  logic             ack_q, ack_d;
  ps2_err_e         err_q, err_d;
  logic [1:0]       dsync_q;
  logic             sync_clk, clk_fall, sync_data, wd_hit;

  ps2_sync_edge #(.FILTER_LEN(FILTER_LEN)) u_clk_sync (
    .clk     (clk),
    .rstn    (rstn),
    .pad_i   (ps2_clk_in),
    .level_o (sync_clk),
    .fall_o  (clk_fall)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) dsync_q <= 2'b11;
    else       dsync_q <= {dsync_q[0], ps2_data_in};
  end
  assign sync_data = dsync_q[1];

  // One counter serves as inhibit timer, then as watchdog from START onward.
  assign wd_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    edge_d      = edge_q;
    data_d      = data_q;
    par_d       = par_q;
    dout_d      = dout_q;
    ack_d       = ack_q;
    err_d       = err_q;
    tx_ready    = 1'b0;
    tx_done     = 1'b0;
    tx_err      = 1'b0;
    err_code    = err_q;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    case (state_q)
      IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          data_d  = tx_data;
          par_d   = odd_par(tx_data);
          cnt_d   = '0;
          state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = START;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      START: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
        cnt_d       = '0;
        edge_d      = '0;
        dout_d      = 1'b1;
        state_d     = SHIFT;
      end
      SHIFT: begin
        ps2_data_oe = dout_q;
        cnt_d       = cnt_q + CNT_W'(1);
        if (clk_fall) begin
          edge_d = edge_q + 4'd1;
          if (edge_q < 4'd8)       dout_d = ~data_q[edge_q[2:0]];
          else if (edge_q == 4'd8) dout_d = ~par_q;
          else if (edge_q == 4'd9) dout_d = 1'b0;
          else begin
            ack_d   = sync_data;
            state_d = ACKWAIT;
          end
        end
        if (wd_hit) begin
          ps2_data_oe = 1'b0;
          tx_err      = 1'b1;
          err_d       = ERR_TIMEOUT;
          err_code    = ERR_TIMEOUT;
          state_d     = IDLE;
        end
      end
      ACKWAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Completion takes priority over a coincident watchdog expiry.
        if (sync_clk && sync_data) begin
          state_d = IDLE;
          if (!ack_q) begin
            tx_done = 1'b1;
          end else begin
            tx_err   = 1'b1;
            err_d    = ERR_NACK;
            err_code = ERR_NACK;
          end
        end else if (wd_hit) begin
          tx_err   = 1'b1;
          err_d    = ERR_TIMEOUT;
          err_code = ERR_TIMEOUT;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      edge_q  <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      dout_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      data_q  <= data_d;
      par_q   <= par_d;
      dout_q  <= dout_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign busy = ~tx_ready;

endmodule
